// File: rtl/rv32i_types.sv
// Shared core-wide types and sizing constants.
//   NUM_REGS   : total physical registers
//   ARCH_REGS  : architectural registers (permanently mapped at reset)
//   phys_reg_t : physical register index, shared by rename, RAT, RRF and ROB
package rv32i_types;
  localparam int NUM_REGS  = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_W    = $clog2(NUM_REGS);

  typedef logic [PHYS_W-1:0] phys_reg_t;
endpackage

// File: rtl/phys_free_list.sv
// Physical register free list for the out-of-order core.
// A circular FIFO of free physical register indices. Rename pops from head,
// commit pushes stale registers at tail. A second, commit-side read pointer
// (arch_head) tracks the architecturally consumed position so a flush can
// roll the speculative head back in one cycle.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   hardware_scheduler_swap_pc  synchronous re-init, same effect as rst
//   alloc_req                   rename consumes alloc_phys this cycle
//   alloc_phys / alloc_valid    head entry (first-word fall-through) / non-empty
//   free_req / free_phys        commit returns a stale physical register
//   flush                       mispredict/exception recovery
//   free_count                  number of free entries
module phys_free_list
  import rv32i_types::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       hardware_scheduler_swap_pc,
  input  logic                                       alloc_req,
  output logic [$clog2(NUM_REGS)-1:0]                alloc_phys,
  output logic                                       alloc_valid,
  input  logic                                       free_req,
  input  logic [$clog2(NUM_REGS)-1:0]                free_phys,
  input  logic                                       flush,
  output logic [$clog2(NUM_REGS-ARCH_REGS+1)-1:0]    free_count
);

  localparam int DEPTH = NUM_REGS - ARCH_REGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  phys_reg_t        mem_reg [DEPTH];
  ptr_t             head_reg;
  ptr_t             tail_reg;
  ptr_t             arch_head_reg;
  logic [CNT_W-1:0] count_reg;

  logic             pop;
  logic             push;
  logic             full;
  ptr_t             head_inc;
  ptr_t             tail_inc;
  ptr_t             arch_head_inc;
  ptr_t             head_next;
  logic [CNT_W-1:0] count_next;

  assign full        = (count_reg == CNT_W'(DEPTH));
  assign alloc_valid = (count_reg != '0);
  assign alloc_phys  = mem_reg[head_reg];
  assign free_count  = count_reg;

  // Flush outranks the pop; a push while full is dropped.
  assign pop  = alloc_req && alloc_valid && !flush;
  assign push = free_req && !full;

  assign head_inc      = wrap_inc(head_reg);
  assign tail_inc      = wrap_inc(tail_reg);
  assign arch_head_inc = wrap_inc(arch_head_reg);

  always_comb begin
    head_next  = head_reg;
    count_next = count_reg;
    if (flush) begin
      // Roll back to the architectural head, including any same-cycle commit.
      head_next  = push ? arch_head_inc : arch_head_reg;
      count_next = CNT_W'(DEPTH);
    end else begin
      if (pop) head_next = head_inc;
      case ({pop, push})
        2'b10:   count_next = count_reg - 1'b1;
        2'b01:   count_next = count_reg + 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= phys_reg_t'(ARCH_REGS + i);
      head_reg      <= '0;
      tail_reg      <= '0;
      arch_head_reg <= '0;
      count_reg     <= CNT_W'(DEPTH);
    end else if (hardware_scheduler_swap_pc) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= phys_reg_t'(ARCH_REGS + i);
      head_reg      <= '0;
      tail_reg      <= '0;
      arch_head_reg <= '0;
      count_reg     <= CNT_W'(DEPTH);
    end else begin
      if (push) begin
        mem_reg[tail_reg] <= free_phys;
        tail_reg          <= tail_inc;
        // Every commit with rd!=x0 consumed one entry architecturally.
        arch_head_reg     <= arch_head_inc;
      end
      head_reg  <= head_next;
      count_reg <= count_next;
    end
  end

  // Pushing into a full list means the caller lost track of ownership.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(free_req && !hardware_scheduler_swap_pc && full));

  // tail - head tracks count modulo DEPTH, so a full list has them equal.
  a_full_ptrs: assert property (@(posedge clk) disable iff (rst)
    full |-> (tail_reg == head_reg));

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;
  import rv32i_types::*;

  localparam int DEPTH = NUM_REGS - ARCH_REGS;

  logic       clk = 0;
  logic       rst = 1;
  logic       swap = 0;
  logic       alloc_req = 0;
  logic [5:0] alloc_phys;
  logic       alloc_valid;
  logic       free_req = 0;
  logic [5:0] free_phys = '0;
  logic       flush = 0;
  logic [5:0] free_count;

  int checks = 0;
  int errors = 0;

  // Reference model: speculative list and architectural list as plain queues.
  logic [5:0] spec_q[$];
  logic [5:0] arch_q[$];

  phys_free_list dut (
    .clk                        (clk),
    .rst                        (rst),
    .hardware_scheduler_swap_pc (swap),
    .alloc_req                  (alloc_req),
    .alloc_phys                 (alloc_phys),
    .alloc_valid                (alloc_valid),
    .free_req                   (free_req),
    .free_phys                  (free_phys),
    .flush                      (flush),
    .free_count                 (free_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    spec_q.delete();
    arch_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      spec_q.push_back(6'(ARCH_REGS + i));
      arch_q.push_back(6'(ARCH_REGS + i));
    end
  endtask

  // Drive one cycle of inputs, update model at the edge, return at the negedge.
  task automatic cycle(input bit a, input bit f, input logic [5:0] fp,
                       input bit fl, input bit sw);
    bit do_pop, do_push;
    alloc_req = a; free_req = f; free_phys = fp; flush = fl; swap = sw;
    @(posedge clk);
    if (sw) model_init();
    else begin
      do_pop  = a && spec_q.size() > 0 && !fl;
      do_push = f && spec_q.size() < DEPTH;
      if (do_pop) void'(spec_q.pop_front());
      if (do_push) begin
        spec_q.push_back(fp);
        void'(arch_q.pop_front());
        arch_q.push_back(fp);
      end
      if (fl) spec_q = arch_q;
    end
    @(negedge clk);
    alloc_req = 0; free_req = 0; flush = 0; swap = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    model_init();
    #5 rst = 0;
    @(negedge clk);
  endtask

  // Compare process: DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    check("model_valid", int'(alloc_valid), int'(spec_q.size() > 0));
    check("model_count", int'(free_count), spec_q.size());
    if (spec_q.size() > 0) check("model_phys", int'(alloc_phys), int'(spec_q[0]));
  end

  initial begin
    logic [5:0] held[$];
    model_init();
    #12 rst = 0;
    @(negedge clk);
    $display("reset: phys=%0d count=%0d valid=%0d", alloc_phys, free_count, alloc_valid);
    check("reset_phys", int'(alloc_phys), 32);
    check("reset_count", int'(free_count), 32);
    check("reset_valid", int'(alloc_valid), 1);

    // 1: drain all 32 entries in order
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_phys", int'(alloc_phys), 32 + i);
      cycle(1, 0, 0, 0, 0);
    end
    $display("drain: valid=%0d count=%0d", alloc_valid, free_count);
    check("drain_valid", int'(alloc_valid), 0);
    check("drain_count", int'(free_count), 0);

    // 2: push into empty list with alloc in the same cycle -> no bypass
    cycle(1, 1, 6'd5, 0, 0);
    $display("push_empty: valid=%0d phys=%0d count=%0d", alloc_valid, alloc_phys, free_count);
    check("nobypass_valid", int'(alloc_valid), 1);
    check("nobypass_phys", int'(alloc_phys), 5);
    check("nobypass_count", int'(free_count), 1);

    // 3: pop 3, commit 1, flush
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 6'd7, 0, 0);
    cycle(0, 0, 0, 1, 0);
    $display("flush: phys=%0d count=%0d", alloc_phys, free_count);
    check("flush_count", int'(free_count), 32);
    check("flush_phys", int'(alloc_phys), 33);

    // 4: flush with simultaneous free and alloc
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 6'd9, 1, 0);
    $display("flush_free: phys=%0d count=%0d", alloc_phys, free_count);
    check("ff_count", int'(free_count), 32);
    check("ff_phys", int'(alloc_phys), 33);
    for (int i = 0; i < 31; i++) cycle(1, 0, 0, 0, 0);
    check("ff_tail_phys", int'(alloc_phys), 9);
    check("ff_tail_count", int'(free_count), 1);

    // 5: steady pop+push across the wrap, recycling popped registers
    do_reset();
    for (int i = 0; i < 4; i++) begin
      held.push_back(alloc_phys);
      cycle(1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 100; i++) begin
      logic [5:0] v;
      v = held.pop_front();
      held.push_back(alloc_phys);
      cycle(1, 1, v, 0, 0);
      check("steady_count", int'(free_count), 28);
    end
    $display("steady: phys=%0d count=%0d", alloc_phys, free_count);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit a, f, fl, sw;
      a  = ($urandom_range(3, 0) != 0);
      f  = ($urandom_range(1, 0) == 1) && (spec_q.size() < DEPTH);
      fl = ($urandom_range(15, 0) == 0);
      sw = ($urandom_range(199, 0) == 0);
      cycle(a, f, 6'($urandom_range(63, 1)), fl, sw);
    end
    $display("random: phys=%0d count=%0d", alloc_phys, free_count);

    // 6: async rst mid-stream, then swap pulse
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    do_reset();
    $display("async_rst: phys=%0d count=%0d", alloc_phys, free_count);
    check("arst_phys", int'(alloc_phys), 32);
    check("arst_count", int'(free_count), 32);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 6'd3, 0, 1);
    $display("swap: phys=%0d count=%0d", alloc_phys, free_count);
    check("swap_phys", int'(alloc_phys), 32);
    check("swap_count", int'(free_count), 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
